// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared FSM encoding and default starvation limit for the DMA/CPU arbiter.
package dm_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;
    localparam int STARVE_LIMIT_DEF = 8;
    localparam int WAIT_CNT_W = 8;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU, DMA and memory port-A signals shared between arbiter and its environment.
interface dm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, dma_gnt, dma_rvalid, dma_rdata, mem_addr, mem_wdata, mem_we
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, dma_gnt, dma_rvalid, dma_rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// dm_arb_starve_cnt: counts consecutive denied DMA cycles and raises o_force for one cycle
// once the count reaches STARVE_LIMIT.
module dm_arb_starve_cnt
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cpu_req,
    input  logic i_dma_req,
    output logic o_force
);
    state_t                r_state;
    state_t                w_state_nx;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nx;
    logic [WAIT_CNT_W-1:0] w_cnt_inc;
    logic                  w_denied;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_wait_cnt <= w_wait_cnt_nx;
        end
    end

    // A denied cycle is the same rule in IDLE and WAIT: IDLE always holds a zero count.
    always_comb begin
        w_denied      = (r_state != ST_FORCE) && i_dma_req && i_cpu_req;
        w_cnt_inc     = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;
        w_wait_cnt_nx = w_denied ? w_cnt_inc : '0;
        w_state_nx    = !w_denied ? ST_IDLE :
                        (w_cnt_inc >= WAIT_CNT_W'(STARVE_LIMIT)) ? ST_FORCE : ST_WAIT;
    end

    assign o_force = (r_state == ST_FORCE);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU-priority arbiter for data-memory port A with DMA starvation guard.
// Define DM_ARB_PERF_EN to add the perf_stall_cnt / perf_dma_cnt counters.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_dma_cnt
`endif
);
    logic          w_force;
    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          w_dma_rd;
    logic [AW-1:0] w_addr;
    logic          r_dma_rvalid;
    logic [DW-1:0] r_dma_rdata;

    dm_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_cpu_req(bus.cpu_req),
        .i_dma_req(bus.dma_req),
        .o_force  (w_force)
    );

    // Grants are masked by rst so nothing reaches memory while reset is held.
    assign w_dma_gnt     = !rst && (w_force || (bus.dma_req && !bus.cpu_req));
    assign w_cpu_gnt     = !rst && !w_force && bus.cpu_req;
    assign w_dma_rd      = w_dma_gnt && !bus.dma_we;
    assign w_addr        = w_dma_gnt ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_we    = w_cpu_gnt ? bus.cpu_we : (w_dma_gnt && bus.dma_we);
    assign bus.cpu_rdata = w_cpu_gnt ? bus.mem_rdata : '0;
    assign bus.cpu_stall = !rst && w_force && bus.cpu_req;
    assign bus.dma_gnt   = w_dma_gnt;
    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.dma_rdata  = r_dma_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_dma_rvalid <= w_dma_rd;
            if (w_dma_rd)
                r_dma_rdata <= bus.mem_rdata;
        end
    end

`ifdef DM_ARB_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_dma_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_dma_cnt   <= '0;
        end else begin
            if (w_force && bus.cpu_req)
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (w_dma_gnt)
                r_perf_dma_cnt <= r_perf_dma_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_dma_cnt   = r_perf_dma_cnt;
`endif
endmodule
